// File: rtl/id_exe_pipe_reg_if.sv
`default_nettype none
// ============================================================================
// Module  : id_exe_pipe_reg_if
// Brief   : ID-to-EX pipeline register bus (decoded instruction in, EX copy out)
// Revision: 1.0 - initial release
// ============================================================================
interface id_exe_pipe_reg_if #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5
);
    logic              IF_ID_Valid;
    logic [DATA_W-1:0] ID_TregData;
    logic [DATA_W-1:0] ID_DregData;
    logic [DATA_W-1:0] ID_ExtendedImm;
    logic              ID_ALUSrc;
    logic              ID_MemNew;
    logic              ID_MemRead;
    logic              ID_RegWrite;
    logic [REG_AW-1:0] ID_Sreg;
    logic [REG_AW-1:0] ID_Treg;
    logic [REG_AW-1:0] ID_Dreg;
    logic              EXE_Stall;
    logic              Flush;

    logic [DATA_W-1:0] ID_EXE_TregData;
    logic [DATA_W-1:0] ID_EXE_DregData;
    logic [DATA_W-1:0] ID_EXE_ExtendedImm;
    logic              ID_EXE_ALUSrc;
    logic              ID_EXE_MemNew;
    logic              ID_EXE_MemRead;
    logic              ID_EXE_RegWrite;
    logic [REG_AW-1:0] ID_EXE_Dreg;
    logic              ID_EXE_Valid;
    logic              ID_Stall;
    logic [15:0]       BubbleCount;

    modport master (
        output IF_ID_Valid, ID_TregData, ID_DregData, ID_ExtendedImm,
               ID_ALUSrc, ID_MemNew, ID_MemRead, ID_RegWrite,
               ID_Sreg, ID_Treg, ID_Dreg, EXE_Stall, Flush,
        input  ID_EXE_TregData, ID_EXE_DregData, ID_EXE_ExtendedImm,
               ID_EXE_ALUSrc, ID_EXE_MemNew, ID_EXE_MemRead, ID_EXE_RegWrite,
               ID_EXE_Dreg, ID_EXE_Valid, ID_Stall, BubbleCount
    );

    modport slave (
        input  IF_ID_Valid, ID_TregData, ID_DregData, ID_ExtendedImm,
               ID_ALUSrc, ID_MemNew, ID_MemRead, ID_RegWrite,
               ID_Sreg, ID_Treg, ID_Dreg, EXE_Stall, Flush,
        output ID_EXE_TregData, ID_EXE_DregData, ID_EXE_ExtendedImm,
               ID_EXE_ALUSrc, ID_EXE_MemNew, ID_EXE_MemRead, ID_EXE_RegWrite,
               ID_EXE_Dreg, ID_EXE_Valid, ID_Stall, BubbleCount
    );
endinterface
`default_nettype wire

// File: rtl/id_exe_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module  : id_exe_pipe_reg
// Brief   : ID/EX pipeline register with load-use hazard bubbling and counter
// Revision: 1.0 - initial release
// ============================================================================
module id_exe_pipe_reg #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    id_exe_pipe_reg_if.slave  bus
);
    localparam logic [15:0] c_count_max = 16'hFFFF;

    logic [DATA_W-1:0] r_treg_data;
    logic [DATA_W-1:0] r_dreg_data;
    logic [DATA_W-1:0] r_ext_imm;
    logic              r_alu_src;
    logic              r_mem_new;
    logic              r_mem_read;
    logic              r_reg_write;
    logic [REG_AW-1:0] r_dreg;
    logic              r_valid;
    logic [15:0]       r_bubble_count;

    logic w_dreg_match;
    logic w_hazard;
    logic w_ctrl_en;

    // Store-type instructions (MemNew) also read their Dreg as a source.
    assign w_dreg_match = (r_dreg == bus.ID_Sreg) || (r_dreg == bus.ID_Treg) ||
                          (bus.ID_MemNew && (r_dreg == bus.ID_Dreg));
    assign w_hazard     = bus.IF_ID_Valid && r_valid && r_mem_read && r_reg_write &&
                          (r_dreg != '0) && w_dreg_match;
    assign w_ctrl_en    = bus.IF_ID_Valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_treg_data    <= '0;
            r_dreg_data    <= '0;
            r_ext_imm      <= '0;
            r_alu_src      <= 1'b0;
            r_mem_new      <= 1'b0;
            r_mem_read     <= 1'b0;
            r_reg_write    <= 1'b0;
            r_dreg         <= '0;
            r_valid        <= 1'b0;
            r_bubble_count <= '0;
        end else if (bus.Flush || (!bus.EXE_Stall && w_hazard)) begin
            r_treg_data <= '0;
            r_dreg_data <= '0;
            r_ext_imm   <= '0;
            r_alu_src   <= 1'b0;
            r_mem_new   <= 1'b0;
            r_mem_read  <= 1'b0;
            r_reg_write <= 1'b0;
            r_dreg      <= '0;
            r_valid     <= 1'b0;
            // Only load-use bubbles are counted, never flushes.
            if (!bus.Flush && (r_bubble_count != c_count_max)) begin
                r_bubble_count <= r_bubble_count + 16'd1;
            end
        end else if (!bus.EXE_Stall) begin
            r_treg_data <= bus.ID_TregData;
            r_dreg_data <= bus.ID_DregData;
            r_ext_imm   <= bus.ID_ExtendedImm;
            r_alu_src   <= bus.ID_ALUSrc   && w_ctrl_en;
            r_mem_new   <= bus.ID_MemNew   && w_ctrl_en;
            r_mem_read  <= bus.ID_MemRead  && w_ctrl_en;
            r_reg_write <= bus.ID_RegWrite && w_ctrl_en;
            r_dreg      <= bus.ID_Dreg;
            r_valid     <= bus.IF_ID_Valid;
        end
    end

    assign bus.ID_EXE_TregData    = r_treg_data;
    assign bus.ID_EXE_DregData    = r_dreg_data;
    assign bus.ID_EXE_ExtendedImm = r_ext_imm;
    assign bus.ID_EXE_ALUSrc      = r_alu_src;
    assign bus.ID_EXE_MemNew      = r_mem_new;
    assign bus.ID_EXE_MemRead     = r_mem_read;
    assign bus.ID_EXE_RegWrite    = r_reg_write;
    assign bus.ID_EXE_Dreg        = r_dreg;
    assign bus.ID_EXE_Valid       = r_valid;
    assign bus.BubbleCount        = r_bubble_count;
    assign bus.ID_Stall           = w_hazard || bus.EXE_Stall;
endmodule
`default_nettype wire

// File: tb/tb_id_exe_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_exe_pipe_reg
// Brief   : Directed self-checking bench for id_exe_pipe_reg
// Revision: 1.0 - initial release
// ============================================================================
module tb_id_exe_pipe_reg;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    id_exe_pipe_reg_if #(.DATA_W(64), .REG_AW(5)) bus ();

    id_exe_pipe_reg #(.DATA_W(64), .REG_AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        bus.IF_ID_Valid    = 1'b0;
        bus.ID_TregData    = '0;
        bus.ID_DregData    = '0;
        bus.ID_ExtendedImm = '0;
        bus.ID_ALUSrc      = 1'b0;
        bus.ID_MemNew      = 1'b0;
        bus.ID_MemRead     = 1'b0;
        bus.ID_RegWrite    = 1'b0;
        bus.ID_Sreg        = '0;
        bus.ID_Treg        = '0;
        bus.ID_Dreg        = '0;
    endtask

    // Put a valid load "ld rD <- ..." into ID.
    task automatic set_load(input logic [4:0] d, input logic [63:0] tdata);
        clear_id();
        bus.IF_ID_Valid = 1'b1;
        bus.ID_MemRead  = 1'b1;
        bus.ID_RegWrite = 1'b1;
        bus.ID_Dreg     = d;
        bus.ID_TregData = tdata;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.Flush = 1'b0;
        bus.EXE_Stall = 1'b0;
        clear_id();
        step();
        step();
        n_checks++; if (bus.ID_EXE_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h expected 0", bus.ID_EXE_Valid); end
        n_checks++; if (bus.BubbleCount !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %0h expected 0", bus.BubbleCount); end
        n_checks++; if (bus.ID_EXE_TregData !== 64'h0) begin n_fail++; $display("FAIL reset_treg: got %0h expected 0", bus.ID_EXE_TregData); end
        bus.EXE_Stall = 1'b1;
        #1;
        n_checks++; if (bus.ID_Stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_hi: got %0h expected 1", bus.ID_Stall); end
        bus.EXE_Stall = 1'b0;
        #1;
        n_checks++; if (bus.ID_Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_lo: got %0h expected 0", bus.ID_Stall); end
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        clear_id();
        bus.IF_ID_Valid    = 1'b1;
        bus.ID_TregData    = 64'h1111;
        bus.ID_ExtendedImm = 64'h20;
        bus.ID_ALUSrc      = 1'b1;
        step();
        n_checks++; if (bus.ID_EXE_TregData !== 64'h1111) begin n_fail++; $display("FAIL load_treg: got %0h expected 1111", bus.ID_EXE_TregData); end
        n_checks++; if (bus.ID_EXE_ExtendedImm !== 64'h20) begin n_fail++; $display("FAIL load_imm: got %0h expected 20", bus.ID_EXE_ExtendedImm); end
        n_checks++; if (bus.ID_EXE_ALUSrc !== 1'b1) begin n_fail++; $display("FAIL load_alusrc: got %0h expected 1", bus.ID_EXE_ALUSrc); end
        n_checks++; if (bus.ID_EXE_Valid !== 1'b1) begin n_fail++; $display("FAIL load_valid: got %0h expected 1", bus.ID_EXE_Valid); end
        n_checks++; if (bus.ID_Stall !== 1'b0) begin n_fail++; $display("FAIL load_stall: got %0h expected 0", bus.ID_Stall); end
    endtask

    task automatic test_invalid_load();
        clear_id();
        bus.ID_ALUSrc   = 1'b1;
        bus.ID_MemRead  = 1'b1;
        bus.ID_RegWrite = 1'b1;
        bus.ID_MemNew   = 1'b1;
        bus.ID_TregData = 64'hABCD;
        bus.ID_Dreg     = 5'd7;
        step();
        n_checks++; if (bus.ID_EXE_Valid !== 1'b0) begin n_fail++; $display("FAIL inv_valid: got %0h expected 0", bus.ID_EXE_Valid); end
        n_checks++; if ({bus.ID_EXE_ALUSrc, bus.ID_EXE_MemNew, bus.ID_EXE_MemRead, bus.ID_EXE_RegWrite} !== 4'b0000) begin n_fail++; $display("FAIL inv_ctrl: got %0b expected 0000", {bus.ID_EXE_ALUSrc, bus.ID_EXE_MemNew, bus.ID_EXE_MemRead, bus.ID_EXE_RegWrite}); end
        n_checks++; if (bus.ID_EXE_TregData !== 64'hABCD) begin n_fail++; $display("FAIL inv_data: got %0h expected abcd", bus.ID_EXE_TregData); end
        n_checks++; if (bus.ID_EXE_Dreg !== 5'd7) begin n_fail++; $display("FAIL inv_dreg: got %0d expected 7", bus.ID_EXE_Dreg); end
    endtask

    task automatic test_load_use();
        set_load(5'd8, 64'h88);
        step();
        clear_id();
        bus.IF_ID_Valid = 1'b1;
        bus.ID_Sreg     = 5'd1;
        bus.ID_Treg     = 5'd8;
        bus.ID_Dreg     = 5'd3;
        bus.ID_RegWrite = 1'b1;
        bus.ID_TregData = 64'h77;
        #1;
        n_checks++; if (bus.ID_Stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %0h expected 1", bus.ID_Stall); end
        step();
        n_checks++; if (bus.ID_EXE_Valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_valid: got %0h expected 0", bus.ID_EXE_Valid); end
        n_checks++; if (bus.BubbleCount !== 16'd1) begin n_fail++; $display("FAIL lu_count: got %0h expected 1", bus.BubbleCount); end
        n_checks++; if (bus.ID_Stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_clear: got %0h expected 0", bus.ID_Stall); end
        step();
        n_checks++; if (bus.ID_EXE_Valid !== 1'b1) begin n_fail++; $display("FAIL lu_reload_valid: got %0h expected 1", bus.ID_EXE_Valid); end
        n_checks++; if (bus.ID_EXE_Dreg !== 5'd3) begin n_fail++; $display("FAIL lu_reload_dreg: got %0d expected 3", bus.ID_EXE_Dreg); end
        n_checks++; if (bus.ID_EXE_TregData !== 64'h77) begin n_fail++; $display("FAIL lu_reload_data: got %0h expected 77", bus.ID_EXE_TregData); end
        n_checks++; if (bus.ID_Stall !== 1'b0) begin n_fail++; $display("FAIL lu_reload_stall: got %0h expected 0", bus.ID_Stall); end
    endtask

    task automatic test_memnew();
        set_load(5'd9, 64'h99);
        step();
        clear_id();
        bus.IF_ID_Valid = 1'b1;
        bus.ID_MemNew   = 1'b1;
        bus.ID_Sreg     = 5'd1;
        bus.ID_Treg     = 5'd2;
        bus.ID_Dreg     = 5'd9;
        #1;
        n_checks++; if (bus.ID_Stall !== 1'b1) begin n_fail++; $display("FAIL mn_store_hazard: got %0h expected 1", bus.ID_Stall); end
        bus.ID_MemNew = 1'b0;
        #1;
        n_checks++; if (bus.ID_Stall !== 1'b0) begin n_fail++; $display("FAIL mn_no_memnew: got %0h expected 0", bus.ID_Stall); end
        set_load(5'd0, 64'h0);
        step();
        clear_id();
        bus.IF_ID_Valid = 1'b1;
        bus.ID_MemNew   = 1'b1;
        #1;
        n_checks++; if (bus.ID_Stall !== 1'b0) begin n_fail++; $display("FAIL mn_r0: got %0h expected 0", bus.ID_Stall); end
        n_checks++; if (bus.BubbleCount !== 16'd1) begin n_fail++; $display("FAIL mn_count: got %0h expected 1", bus.BubbleCount); end
    endtask

    task automatic test_priority();
        set_load(5'd5, 64'h55);
        bus.Flush     = 1'b1;
        bus.EXE_Stall = 1'b1;
        step();
        n_checks++; if (bus.ID_EXE_Valid !== 1'b0) begin n_fail++; $display("FAIL pr_flush_valid: got %0h expected 0", bus.ID_EXE_Valid); end
        n_checks++; if ({bus.ID_EXE_MemRead, bus.ID_EXE_RegWrite, bus.ID_EXE_Dreg} !== 7'd0) begin n_fail++; $display("FAIL pr_flush_ctrl: got %0h expected 0", {bus.ID_EXE_MemRead, bus.ID_EXE_RegWrite, bus.ID_EXE_Dreg}); end
        n_checks++; if (bus.ID_EXE_TregData !== 64'h0) begin n_fail++; $display("FAIL pr_flush_data: got %0h expected 0", bus.ID_EXE_TregData); end
        bus.Flush     = 1'b0;
        bus.EXE_Stall = 1'b0;
        step();
        n_checks++; if (bus.ID_EXE_Dreg !== 5'd5) begin n_fail++; $display("FAIL pr_load_dreg: got %0d expected 5", bus.ID_EXE_Dreg); end
        clear_id();
        bus.IF_ID_Valid = 1'b1;
        bus.ID_Sreg     = 5'd1;
        bus.ID_Treg     = 5'd5;
        bus.ID_Dreg     = 5'd6;
        bus.ID_RegWrite = 1'b1;
        bus.ID_TregData = 64'h66;
        bus.EXE_Stall   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (bus.ID_EXE_Valid !== 1'b1 || bus.ID_EXE_Dreg !== 5'd5 || bus.ID_EXE_TregData !== 64'h55) begin n_fail++; $display("FAIL pr_hold_%0d: got v=%0h d=%0d t=%0h expected v=1 d=5 t=55", i, bus.ID_EXE_Valid, bus.ID_EXE_Dreg, bus.ID_EXE_TregData); end
            n_checks++; if (bus.BubbleCount !== 16'd1) begin n_fail++; $display("FAIL pr_hold_count_%0d: got %0h expected 1", i, bus.BubbleCount); end
        end
        bus.EXE_Stall = 1'b0;
        step();
        n_checks++; if (bus.ID_EXE_Valid !== 1'b0 || bus.BubbleCount !== 16'd2) begin n_fail++; $display("FAIL pr_bubble: got v=%0h c=%0h expected v=0 c=2", bus.ID_EXE_Valid, bus.BubbleCount); end
        step();
        n_checks++; if (bus.ID_EXE_Dreg !== 5'd6 || bus.ID_EXE_Valid !== 1'b1) begin n_fail++; $display("FAIL pr_after: got d=%0d v=%0h expected d=6 v=1", bus.ID_EXE_Dreg, bus.ID_EXE_Valid); end
    endtask

    task automatic test_saturation_reset();
        force dut.r_bubble_count = 16'hFFFE;
        #1;
        release dut.r_bubble_count;
        #1;
        n_checks++; if (bus.BubbleCount !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preload: got %0h expected fffe", bus.BubbleCount); end
        set_load(5'd5, 64'h5);
        bus.ID_Sreg = 5'd5;
        bus.ID_Treg = 5'd5;
        step();
        step();
        n_checks++; if (bus.BubbleCount !== 16'hFFFF) begin n_fail++; $display("FAIL sat_first: got %0h expected ffff", bus.BubbleCount); end
        step();
        step();
        n_checks++; if (bus.BubbleCount !== 16'hFFFF || bus.ID_EXE_Valid !== 1'b0) begin n_fail++; $display("FAIL sat_hold: got c=%0h v=%0h expected c=ffff v=0", bus.BubbleCount, bus.ID_EXE_Valid); end
        step();
        rst_n = 1'b0;
        bus.EXE_Stall = 1'b1;
        #1;
        n_checks++; if (bus.ID_EXE_Valid !== 1'b0 || bus.BubbleCount !== 16'h0) begin n_fail++; $display("FAIL async_rst: got v=%0h c=%0h expected 0 0", bus.ID_EXE_Valid, bus.BubbleCount); end
        n_checks++; if (bus.ID_EXE_Dreg !== 5'd0 || bus.ID_EXE_TregData !== 64'h0 || bus.ID_EXE_MemRead !== 1'b0) begin n_fail++; $display("FAIL async_rst_regs: got d=%0d t=%0h m=%0h expected 0", bus.ID_EXE_Dreg, bus.ID_EXE_TregData, bus.ID_EXE_MemRead); end
        n_checks++; if (bus.ID_Stall !== 1'b1) begin n_fail++; $display("FAIL async_rst_stall: got %0h expected 1", bus.ID_Stall); end
        #3;
        rst_n = 1'b1;
        bus.EXE_Stall = 1'b0;
        clear_id();
        bus.IF_ID_Valid = 1'b1;
        bus.ID_TregData = 64'h1234;
        step();
        n_checks++; if (bus.ID_EXE_Valid !== 1'b1 || bus.ID_EXE_TregData !== 64'h1234 || bus.BubbleCount !== 16'h0) begin n_fail++; $display("FAIL post_rst_load: got v=%0h t=%0h c=%0h expected 1 1234 0", bus.ID_EXE_Valid, bus.ID_EXE_TregData, bus.BubbleCount); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_load();
        test_invalid_load();
        test_load_use();
        test_memnew();
        test_priority();
        test_saturation_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/id_exe_pipe_reg.md
ID_EXE_PIPE_REG -- requirements
Module: id_exe_pipe_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64, operand datapath width.
REQ-002 SHALL have parameter REG_AW, default 5, register-address width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port IF_ID_Valid  in  1  ID holds a real instruction.
REQ-006 SHALL have ports ID_TregData, ID_DregData, ID_ExtendedImm  in  DATA_W  decoded operands.
REQ-007 SHALL have ports ID_ALUSrc, ID_MemNew, ID_MemRead, ID_RegWrite  in  1  decoded controls.
REQ-008 SHALL have ports ID_Sreg, ID_Treg, ID_Dreg  in  REG_AW  register addresses of the ID instruction.
REQ-009 SHALL have port EXE_Stall  in  1  downstream hold request.
REQ-010 SHALL have port Flush  in  1  branch/exception squash.
REQ-011 SHALL have ports ID_EXE_TregData, ID_EXE_DregData, ID_EXE_ExtendedImm  out  DATA_W  registered operands to EX operand muxing.
REQ-012 SHALL have ports ID_EXE_ALUSrc, ID_EXE_MemNew, ID_EXE_MemRead, ID_EXE_RegWrite  out  1  registered controls.
REQ-013 SHALL have port ID_EXE_Dreg  out  REG_AW  registered destination address.
REQ-014 SHALL have port ID_EXE_Valid  out  1  EX-stage instruction is real.
REQ-015 SHALL have port ID_Stall  out  1  freeze IF/ID (combinational).
REQ-016 SHALL have port BubbleCount  out  16  count of load-use bubbles inserted.

Function
REQ-017 Hazard SHALL be: IF_ID_Valid & ID_EXE_Valid & ID_EXE_MemRead & ID_EXE_RegWrite & ID_EXE_Dreg!=0 & (ID_EXE_Dreg==ID_Sreg | ID_EXE_Dreg==ID_Treg | (ID_MemNew & ID_EXE_Dreg==ID_Dreg)).
REQ-018 ID_Stall SHALL equal Hazard | EXE_Stall, with no registered delay.
REQ-019 Per-edge priority SHALL be: Flush > EXE_Stall > Hazard > Load.
REQ-020 Flush SHALL load bubble: Valid, all controls, Dreg and data outputs to 0, regardless of EXE_Stall.
REQ-021 EXE_Stall (no Flush) SHALL hold every output register unchanged.
REQ-022 Hazard (no Flush, no EXE_Stall) SHALL load bubble as REQ-020 and increment BubbleCount by 1.
REQ-023 Load SHALL capture all ID_* inputs into ID_EXE_* outputs; ID_EXE_Valid <= IF_ID_Valid.
REQ-024 Load with IF_ID_Valid=0 SHALL force all controls to 0 (data captured as presented).
REQ-025 Latency SHALL be exactly one cycle from ID inputs to ID_EXE_* outputs on Load.
REQ-026 BubbleCount SHALL saturate at 16'hFFFF; no wrap.
REQ-027 A hazard bubble SHALL clear ID_EXE_Valid, so Hazard deasserts the following cycle and the held ID instruction loads one cycle later (exactly one bubble per load-use pair).
REQ-028 Address 0 as destination SHALL never raise Hazard.

Reset
REQ-029 rst_n low SHALL immediately (asynchronously) clear all ID_EXE_* outputs, ID_EXE_Valid and BubbleCount to 0.
REQ-030 Reset assertion mid-stall or mid-bubble SHALL discard pending state; first edge after rst_n rises SHALL follow REQ-019 normally.
REQ-031 During reset ID_Stall SHALL equal EXE_Stall (Hazard term is 0 because ID_EXE_Valid=0).

Verification
REQ-032 Load: ID_TregData=64'h1111, ID_ExtendedImm=64'h20, ID_ALUSrc=1, IF_ID_Valid=1 -> next edge outputs match, ID_EXE_Valid=1, ID_Stall=0.
REQ-033 Load-use: EX holds MemRead=1, RegWrite=1, Dreg=8; ID Treg=8 -> ID_Stall=1 same cycle; next edge Valid=0, BubbleCount=1; following edge ID instruction loads, ID_Stall=0.
REQ-034 MemNew store: EX load Dreg=9; ID MemNew=1, ID_Dreg=9, Sreg/Treg!=9 -> Hazard; with ID_MemNew=0 -> no Hazard; with EX Dreg=0 -> no Hazard.
REQ-035 Priority: Flush=1 and EXE_Stall=1 together -> bubble loaded; EXE_Stall=1 alone for 3 cycles -> outputs frozen, BubbleCount unchanged even if Hazard true.
REQ-036 Saturation/reset: preload 16'hFFFE, two hazards -> 16'hFFFF held; drop rst_n between edges -> all outputs 0 before next edge.
